// File: rtl/tbec_rsc_pkg.sv
// ============================================================================
// Module      : tbec_rsc_pkg
// Description : Shared constants, flag encodings and syndrome record for the
//               TBEC-RSC decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tbec_rsc_pkg;

    localparam int CODE_W = 32;
    localparam int DATA_W = 16;
    localparam int RED_W  = 16;

    typedef logic [2:0] flag_t;

    localparam flag_t FLAG_NONE    = 3'b000;
    localparam flag_t FLAG_Q1      = 3'b100;
    localparam flag_t FLAG_Q2      = 3'b010;
    localparam flag_t FLAG_CENTRAL = 3'b001;

    // l[2r+j] is line syndrome L[r][j]; sp[k]/sd[k] are SPk/SDk
    typedef struct packed {
        logic [7:0] l;
        logic [3:0] sp;
        logic [3:0] sd;
    } syn_t;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tbec_rsc_lane_core.sv
// ============================================================================
// Module      : tbec_rsc_lane_core
// Description : Combinational syndrome generation and quadrant correction for
//               one TBEC-RSC lane. Syndromes and correction have separate
//               ports so they can sit on either side of a pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tbec_rsc_lane_core
    import tbec_rsc_pkg::*;
(
    input  logic [CODE_W-1:0] syn_code,
    output syn_t              syn,
    input  logic [DATA_W-1:0] cor_data,
    input  syn_t              cor_syn,
    input  logic              cor_bypass,
    output logic [DATA_W-1:0] out_data,
    output flag_t             out_flag,
    output logic              out_uncorr
);

    // codeword bit 0 lives in the vector MSB
    logic [DATA_W-1:0]    w_d;
    logic [RED_W-1:0]     w_r;
    logic [DATA_W-1:0]    w_cd;
    logic [3:0][3:0]      w_s;
    logic [3:0][3:0]      w_fix;
    logic [3:0]           w_nl;
    logic [3:0]           w_np;
    logic [3:0]           w_nd;
    logic [2:0]           w_q1;
    logic [2:0]           w_q2;
    logic                 w_trig;

    always_comb begin
        w_d = '0;
        w_r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_d[i] = syn_code[CODE_W-1-i];
            w_r[i] = syn_code[RED_W-1-i];
        end
    end

    always_comb begin
        syn = '0;
        for (int r = 0; r < 4; r++) begin
            syn.l[2*r]   = w_d[r]   ^ w_d[r+8]  ^ w_r[8+2*r];
            syn.l[2*r+1] = w_d[r+4] ^ w_d[r+12] ^ w_r[9+2*r];
        end
        syn.sp[0] = w_d[0]  ^ w_d[4]  ^ w_d[1]  ^ w_d[5]  ^ w_r[4];
        syn.sp[1] = w_d[2]  ^ w_d[6]  ^ w_d[3]  ^ w_d[7]  ^ w_r[6];
        syn.sp[2] = w_d[8]  ^ w_d[12] ^ w_d[9]  ^ w_d[13] ^ w_r[7];
        syn.sp[3] = w_d[10] ^ w_d[14] ^ w_d[11] ^ w_d[15] ^ w_r[5];
        syn.sd[0] = w_d[0]  ^ w_d[5]  ^ w_d[2]  ^ w_d[7]  ^ w_r[0];
        syn.sd[1] = w_d[4]  ^ w_d[1]  ^ w_d[6]  ^ w_d[3]  ^ w_r[2];
        syn.sd[2] = w_d[8]  ^ w_d[13] ^ w_d[10] ^ w_d[15] ^ w_r[3];
        syn.sd[3] = w_d[12] ^ w_d[9]  ^ w_d[14] ^ w_d[11] ^ w_r[1];
    end

    // Matrix view: s[r][j] = d[r+4j]
    always_comb begin
        w_cd = '0;
        w_s  = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_cd[i] = cor_data[DATA_W-1-i];
        end
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                w_s[r][j] = w_cd[r+4*j];
            end
        end
    end

    assign w_nl = popcnt8(cor_syn.l);
    assign w_np = popcnt8({4'b0000, cor_syn.sp});
    assign w_nd = popcnt8({4'b0000, cor_syn.sd});
    assign w_q1 = {2'b00, cor_syn.sp[0]} + {2'b00, cor_syn.sp[1]}
                + {2'b00, cor_syn.sd[0]} + {2'b00, cor_syn.sd[1]};
    assign w_q2 = {2'b00, cor_syn.sp[2]} + {2'b00, cor_syn.sp[3]}
                + {2'b00, cor_syn.sd[2]} + {2'b00, cor_syn.sd[3]};

    // A lone parity hit with clean diagonals is line noise, not a data error
    assign w_trig = (((|cor_syn.sp) && (|cor_syn.sd)) || (w_nl > 4'd1))
                  && !((w_nd == 4'd0) && (w_np == 4'd1) && (w_nl >= 4'd2));

    always_comb begin
        w_fix      = w_s;
        out_flag   = FLAG_NONE;
        out_uncorr = 1'b0;
        if (!cor_bypass && w_trig) begin
            if (w_q1 > w_q2) begin
                out_flag = FLAG_Q1;
                for (int r = 0; r < 4; r++) begin
                    w_fix[r][0] = w_s[r][0] ^ cor_syn.l[2*r];
                    w_fix[r][1] = w_s[r][1] ^ cor_syn.l[2*r+1];
                end
            end else if (w_q1 < w_q2) begin
                out_flag = FLAG_Q2;
                for (int r = 0; r < 4; r++) begin
                    w_fix[r][2] = w_s[r][2] ^ cor_syn.l[2*r];
                    w_fix[r][3] = w_s[r][3] ^ cor_syn.l[2*r+1];
                end
            end else if ({cor_syn.sp[0], cor_syn.sp[1], cor_syn.sd[0], cor_syn.sd[1]} != 4'b0000) begin
                out_flag = FLAG_CENTRAL;
                for (int r = 0; r < 4; r++) begin
                    w_fix[r][1] = w_s[r][1] ^ cor_syn.l[2*r+1];
                    w_fix[r][2] = w_s[r][2] ^ cor_syn.l[2*r];
                end
            end else begin
                out_uncorr = 1'b1;
            end
        end
    end

    // Output is row-major: {row0,row1,row2,row3}, s[0][0] at the MSB
    always_comb begin
        out_data = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                out_data[DATA_W-1-4*r-j] = w_fix[r][j];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tbec_rsc_decoder_pipe.sv
// ============================================================================
// Module      : tbec_rsc_decoder_pipe
// Description : Multi-lane TBEC-RSC decoder with valid/ready stream, 2-stage
//               pipeline and saturating correction counters.
//               Optional macro TBEC_BYPASS_EN adds a per-beat bypass input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tbec_rsc_decoder_pipe
    import tbec_rsc_pkg::*;
#(
    parameter int LANES = 2,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CODE_W*LANES-1:0] in_code,
`ifdef TBEC_BYPASS_EN
    input  logic                    bypass,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W*LANES-1:0] out_data,
    output logic [3*LANES-1:0]      out_flag,
    output logic [LANES-1:0]        out_uncorr,
    output logic [CNT_W-1:0]        corr_cnt,
    output logic [CNT_W-1:0]        uncorr_cnt,
    input  logic                    cnt_clr
);

    localparam logic [CNT_W+3:0] c_cnt_max = {4'b0000, {CNT_W{1'b1}}};

    logic                    w_in_bypass;
    logic [DATA_W*LANES-1:0] w_in_data;
    syn_t [LANES-1:0]        w_syn;
    logic [DATA_W*LANES-1:0] w_cor_data;
    logic [3*LANES-1:0]      w_cor_flag;
    logic [LANES-1:0]        w_cor_uncorr;
    logic                    w_adv_b;

    logic                    r_a_valid;
    logic [DATA_W*LANES-1:0] r_a_data;
    syn_t [LANES-1:0]        r_a_syn;
    logic                    r_a_bypass;

    logic                    r_out_valid;
    logic [DATA_W*LANES-1:0] r_out_data;
    logic [3*LANES-1:0]      r_out_flag;
    logic [LANES-1:0]        r_out_uncorr;
    logic [CNT_W-1:0]        r_corr_cnt;
    logic [CNT_W-1:0]        r_uncorr_cnt;

    logic [3:0]              w_corr_inc;
    logic [3:0]              w_uncorr_inc;
    logic [CNT_W+3:0]        w_corr_sum;
    logic [CNT_W+3:0]        w_uncorr_sum;

`ifdef TBEC_BYPASS_EN
    assign w_in_bypass = bypass;
`else
    assign w_in_bypass = 1'b0;
`endif

    // Only the data half is kept; the redundancy is fully summarised by w_syn
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_in_data[k*DATA_W +: DATA_W] = in_code[k*CODE_W+RED_W +: DATA_W];

        tbec_rsc_lane_core u_core (
            .syn_code   (in_code[k*CODE_W +: CODE_W]),
            .syn        (w_syn[k]),
            .cor_data   (r_a_data[k*DATA_W +: DATA_W]),
            .cor_syn    (r_a_syn[k]),
            .cor_bypass (r_a_bypass),
            .out_data   (w_cor_data[k*DATA_W +: DATA_W]),
            .out_flag   (w_cor_flag[k*3 +: 3]),
            .out_uncorr (w_cor_uncorr[k])
        );
    end

    assign w_adv_b  = !r_out_valid || out_ready;
    assign in_ready = !r_a_valid || w_adv_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid  <= 1'b0;
            r_a_data   <= '0;
            r_a_syn    <= '0;
            r_a_bypass <= 1'b0;
        end else if (in_ready) begin
            r_a_valid <= in_valid;
            if (in_valid) begin
                r_a_data   <= w_in_data;
                r_a_syn    <= w_syn;
                r_a_bypass <= w_in_bypass;
            end
        end
    end

    // Payload only moves when stage A hands over, so it holds under a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_flag   <= '0;
            r_out_uncorr <= '0;
        end else if (w_adv_b) begin
            r_out_valid <= r_a_valid;
            if (r_a_valid) begin
                r_out_data   <= w_cor_data;
                r_out_flag   <= w_cor_flag;
                r_out_uncorr <= w_cor_uncorr;
            end
        end
    end

    always_comb begin
        w_corr_inc   = '0;
        w_uncorr_inc = '0;
        for (int k = 0; k < LANES; k++) begin
            w_corr_inc   = w_corr_inc   + {3'b000, |r_out_flag[k*3 +: 3]};
            w_uncorr_inc = w_uncorr_inc + {3'b000, r_out_uncorr[k]};
        end
    end

    assign w_corr_sum   = {4'b0000, r_corr_cnt}   + {{CNT_W{1'b0}}, w_corr_inc};
    assign w_uncorr_sum = {4'b0000, r_uncorr_cnt} + {{CNT_W{1'b0}}, w_uncorr_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (r_out_valid && out_ready) begin
            r_corr_cnt   <= (w_corr_sum > c_cnt_max) ? c_cnt_max[CNT_W-1:0]
                                                     : w_corr_sum[CNT_W-1:0];
            r_uncorr_cnt <= (w_uncorr_sum > c_cnt_max) ? c_cnt_max[CNT_W-1:0]
                                                       : w_uncorr_sum[CNT_W-1:0];
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_flag   = r_out_flag;
    assign out_uncorr = r_out_uncorr;
    assign corr_cnt   = r_corr_cnt;
    assign uncorr_cnt = r_uncorr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tbec_rsc_decoder_pipe.sv
// ============================================================================
// Module      : tb_tbec_rsc_decoder_pipe
// Description : Directed self-checking bench for tbec_rsc_decoder_pipe
//               (2-lane main instance, 1-lane CNT_W=2 instance for saturation).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tbec_rsc_decoder_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_code = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [5:0]  out_flag;
    logic [1:0]  out_uncorr;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;
    logic        cnt_clr = 1'b0;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [31:0] in_code2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [15:0] out_data2;
    logic [2:0]  out_flag2;
    logic [0:0]  out_uncorr2;
    logic [1:0]  corr_cnt2;
    logic [1:0]  uncorr_cnt2;
    logic        cnt_clr2 = 1'b0;

`ifdef TBEC_BYPASS_EN
    logic        bypass = 1'b0;
    logic        bypass2 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int exp_corr = 0;
    int exp_uncorr = 0;

    always #5 clk = ~clk;

    tbec_rsc_decoder_pipe #(.LANES(2), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
`ifdef TBEC_BYPASS_EN
        .bypass     (bypass),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_flag   (out_flag),
        .out_uncorr (out_uncorr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt),
        .cnt_clr    (cnt_clr)
    );

    tbec_rsc_decoder_pipe #(.LANES(1), .CNT_W(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .in_code    (in_code2),
`ifdef TBEC_BYPASS_EN
        .bypass     (bypass2),
`endif
        .out_valid  (out_valid2),
        .out_ready  (out_ready2),
        .out_data   (out_data2),
        .out_flag   (out_flag2),
        .out_uncorr (out_uncorr2),
        .corr_cnt   (corr_cnt2),
        .uncorr_cnt (uncorr_cnt2),
        .cnt_clr    (cnt_clr2)
    );

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset out_data: got %h expected 00000000", out_data); end
        checks++; if (out_flag !== 6'h0 || out_uncorr !== 2'b00) begin errors++; $display("FAIL reset flags: got %b/%b expected 0", out_flag, out_uncorr); end
        checks++; if (corr_cnt !== 16'h0 || uncorr_cnt !== 16'h0) begin errors++; $display("FAIL reset counters: got %0d/%0d expected 0/0", corr_cnt, uncorr_cnt); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_decode();
        logic [31:0] c0 [7] = '{32'h00000000, 32'h80000000, 32'h00800000, 32'h08800000, 32'h7FFF0000, 32'h00000000, 32'h00000800};
        logic [31:0] c1 [7] = '{32'h00000000, 32'h40002820, 32'h80008880, 32'h000000A0, 32'hFFFF0000, 32'h00800000, 32'h00000001};
        logic [15:0] d0 [7] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        logic [15:0] d1 [7] = '{16'h0000, 16'h0800, 16'h8000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        logic [2:0]  f0 [7] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b100, 3'b000, 3'b000};
        logic [2:0]  f1 [7] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000};
        logic [1:0]  un [7] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        for (int v = 0; v < 7; v++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_code  = {c1[v], c0[v]};
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL decode[%0d] early out_valid: got %b expected 0", v, out_valid); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL decode[%0d] out_valid: got %b expected 1", v, out_valid); end
            checks++; if (out_data !== {d1[v], d0[v]}) begin errors++; $display("FAIL decode[%0d] out_data: got %h expected %h", v, out_data, {d1[v], d0[v]}); end
            checks++; if (out_flag !== {f1[v], f0[v]}) begin errors++; $display("FAIL decode[%0d] out_flag: got %b expected %b", v, out_flag, {f1[v], f0[v]}); end
            checks++; if (out_uncorr !== un[v]) begin errors++; $display("FAIL decode[%0d] out_uncorr: got %b expected %b", v, out_uncorr, un[v]); end
            exp_corr   += int'(f0[v] != 3'b000) + int'(f1[v] != 3'b000);
            exp_uncorr += int'(un[v][0]) + int'(un[v][1]);
            @(posedge clk); #1;
            checks++; if (corr_cnt !== 16'(exp_corr)) begin errors++; $display("FAIL decode[%0d] corr_cnt: got %0d expected %0d", v, corr_cnt, exp_corr); end
            checks++; if (uncorr_cnt !== 16'(exp_uncorr)) begin errors++; $display("FAIL decode[%0d] uncorr_cnt: got %0d expected %0d", v, uncorr_cnt, exp_uncorr); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] codes [10] = '{32'h80008880, 32'h40002820, 32'h20008208, 32'h10002202, 32'h08002840,
                                    32'hC000A0A0, 32'h3000A00A, 32'hFFFF0000, 32'h00000000, 32'h8800A0C0};
        logic [15:0] datas [10] = '{16'h8000, 16'h0800, 16'h0080, 16'h0008, 16'h4000,
                                    16'h8800, 16'h0088, 16'hFFFF, 16'h0000, 16'hC000};
        int sent = 0;
        int rcv = 0;
        bit stalled_prev = 1'b0;
        bit saw_block = 1'b0;
        bit fire_in;
        bit fire_out;
        logic [31:0] held = '0;
        logic [31:0] exp;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 60 && rcv < 10; cyc++) begin
            in_valid  = (sent < 10);
            in_code   = {codes[(sent + 5) % 10], codes[sent % 10]};
            out_ready = !(cyc >= 4 && cyc <= 6);
            #1;
            if (!out_ready && !in_ready) saw_block = 1'b1;
            if (stalled_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    errors++; $display("FAIL b2b stall hold cyc %0d: got %b/%h expected 1/%h", cyc, out_valid, out_data, held);
                end
            end
            if (out_valid === 1'b1) begin
                exp = {datas[(rcv + 5) % 10], datas[rcv % 10]};
                checks++;
                if (out_data !== exp || out_flag !== 6'h0) begin
                    errors++; $display("FAIL b2b beat %0d: got %h/%b expected %h/000000", rcv, out_data, out_flag, exp);
                end
            end
            stalled_prev = (out_valid === 1'b1) && !out_ready;
            held     = out_data;
            fire_in  = in_valid && (in_ready === 1'b1);
            fire_out = (out_valid === 1'b1) && out_ready;
            @(posedge clk); #1;
            sent += int'(fire_in);
            rcv  += int'(fire_out);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (rcv != 10 || sent != 10) begin errors++; $display("FAIL b2b count: got sent %0d rcv %0d expected 10/10", sent, rcv); end
        checks++; if (!saw_block) begin errors++; $display("FAIL b2b in_ready: got never low expected low while stalled"); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b duplicate: got out_valid %b expected 0", out_valid); end
        checks++; if (corr_cnt !== 16'(exp_corr)) begin errors++; $display("FAIL b2b corr_cnt: got %0d expected %0d", corr_cnt, exp_corr); end
    endtask

    task automatic test_saturate_clear();
        int exp2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid2 = 1'b1;
            in_code2  = 32'h80000000;
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            @(posedge clk); #1;
            checks++; if (out_valid2 !== 1'b1 || out_flag2 !== 3'b100) begin errors++; $display("FAIL sat[%0d] beat: got %b/%b expected 1/100", i, out_valid2, out_flag2); end
            cnt_clr2 = (i == 4);
            @(posedge clk); #1;
            cnt_clr2 = 1'b0;
            exp2 = (i == 4) ? 0 : ((i + 1 > 3) ? 3 : i + 1);
            checks++; if (corr_cnt2 !== 2'(exp2)) begin errors++; $display("FAIL sat[%0d] corr_cnt: got %0d expected %0d", i, corr_cnt2, exp2); end
        end
        // One more correction so the async reset has something to clear
        @(posedge clk); #1;
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (corr_cnt2 !== 2'd1) begin errors++; $display("FAIL sat post-clear corr_cnt: got %0d expected 1", corr_cnt2); end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = {32'h00000000, 32'h80000000};
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL areset setup: got valid %b ready %b expected 1/0", out_valid, in_ready); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0 || out_flag !== 6'h0 || out_uncorr !== 2'b00) begin errors++; $display("FAIL areset payload: got %h/%b/%b expected 0", out_data, out_flag, out_uncorr); end
        checks++; if (corr_cnt !== 16'h0 || uncorr_cnt !== 16'h0) begin errors++; $display("FAIL areset counters: got %0d/%0d expected 0/0", corr_cnt, uncorr_cnt); end
        checks++; if (corr_cnt2 !== 2'd0) begin errors++; $display("FAIL areset corr_cnt2: got %0d expected 0", corr_cnt2); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        exp_corr   = 0;
        exp_uncorr = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset discard: got out_valid %b expected 0", out_valid); end
        checks++; if (corr_cnt !== 16'(exp_corr)) begin errors++; $display("FAIL areset recount: got %0d expected %0d", corr_cnt, exp_corr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_saturate_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
